// File: rtl/fsm_batch_ctrl_pkg.sv
// Shared types for the load/process controller family: state encoding,
// reduction modes and the result-width helper.
package fsm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PROCESS = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_XOR = 1'b1;

  // Result width wide enough that a sum of beats*max_word never overflows.
  function automatic int res_width(input int data_w, input int beats);
    return data_w + $clog2(beats);
  endfunction

endpackage

// File: rtl/fsm_batch_ctrl_if.sv
// Stream handshakes of the batch controller: word input and result output.
// master = upstream source / downstream consumer side, slave = controller.
interface fsm_batch_ctrl_if
  import fsm_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOAD_BEATS = 4
);

  localparam int RES_W = res_width(DATA_W, LOAD_BEATS);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fsm_batch_ctrl_tick_counter.sv
// Clearable up-counter with a terminal-count flag; used for both the beat
// count of a batch and the processing-latency count.
module fsm_tick_counter
  import fsm_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);

  logic [WIDTH-1:0] cnt_reg;

  // Count enabled cycles; clear has priority over enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

  assign cnt    = cnt_reg;
  assign at_max = (cnt_reg == WIDTH'(MAX));

endmodule

// File: rtl/fsm_batch_ctrl.sv
// Batch load/process controller: collects LOAD_BEATS words, reduces them by
// sum or XOR, waits PROC_CYCLES cycles, then offers the result downstream.
module fsm_batch_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LOAD_BEATS  = 4,
  parameter int PROC_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 abort,
  input  logic                 mode,
  fsm_batch_ctrl_if.slave      bus,
  output logic [1:0]           state,
  output logic [15:0]          batch_cnt
);

  localparam int RES_W  = res_width(DATA_W, LOAD_BEATS);
  localparam int BEAT_W = $clog2(LOAD_BEATS) + 1;
  localparam int CYC_W  = $clog2(PROC_CYCLES) + 1;

  state_t             state_reg, state_next;
  logic [RES_W-1:0]   acc_reg, acc_next;
  logic [RES_W-1:0]   out_data_reg;
  logic [RES_W-1:0]   data_ext;
  logic               mode_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [15:0]        batch_cnt_reg;
  logic               in_xfer, out_xfer;
  logic               beat_last, cyc_last;
  logic               beat_clr, cyc_clr, cyc_en;
  logic [BEAT_W-1:0]  beat_cnt_unused;
  logic [CYC_W-1:0]   cyc_cnt_unused;

  // Handshakes are qualified by the registered flags so that a word arriving
  // in the same cycle as abort is never consumed.
  assign in_xfer  = bus.in_valid && in_ready_reg && !abort;
  assign out_xfer = out_valid_reg && bus.out_ready && !abort;
  assign data_ext = RES_W'(bus.in_data);

  // Beat counter: terminal value marks the last word of a batch.
  assign beat_clr = abort || (in_xfer && beat_last);

  fsm_tick_counter #(
    .WIDTH (BEAT_W),
    .MAX   (LOAD_BEATS - 1)
  ) u_beat_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (beat_clr),
    .en     (in_xfer),
    .cnt    (beat_cnt_unused),
    .at_max (beat_last)
  );

  // Processing-latency counter: runs only while in PROCESS.
  assign cyc_en  = (state_reg == PROCESS);
  assign cyc_clr = abort || !cyc_en || cyc_last;

  fsm_tick_counter #(
    .WIDTH (CYC_W),
    .MAX   (PROC_CYCLES - 1)
  ) u_cyc_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cyc_clr),
    .en     (cyc_en),
    .cnt    (cyc_cnt_unused),
    .at_max (cyc_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and accumulator update; abort overrides everything.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    if (abort) begin
      state_next = IDLE;
      acc_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_xfer) begin
            acc_next   = data_ext;
            state_next = (LOAD_BEATS == 1) ? PROCESS : LOAD;
          end
        end
        LOAD: begin
          if (in_xfer) begin
            acc_next = (mode_reg == MODE_XOR) ? (acc_reg ^ data_ext)
                                              : (acc_reg + data_ext);
            if (beat_last) state_next = PROCESS;
          end
        end
        PROCESS: begin
          if (cyc_last) state_next = DONE;
        end
        DONE: begin
          if (out_xfer) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and registered handshake outputs, derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      mode_reg      <= MODE_SUM;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      batch_cnt_reg <= '0;
    end else begin
      acc_reg       <= acc_next;
      in_ready_reg  <= (state_next == IDLE) || (state_next == LOAD);
      out_valid_reg <= (state_next == DONE);
      if (abort) begin
        mode_reg     <= MODE_SUM;
        out_data_reg <= '0;
      end else begin
        if (in_xfer && state_reg == IDLE) mode_reg <= mode;
        if (state_reg == PROCESS && state_next == DONE) out_data_reg <= acc_reg;
        if (out_xfer) batch_cnt_reg <= batch_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign state         = state_reg;
  assign batch_cnt     = batch_cnt_reg;

endmodule

// File: tb/tb_fsm_batch_ctrl.sv
// Self-checking bench for fsm_batch_ctrl: batches are modelled on drive and
// their expected results queued; results are popped as the DUT hands them off.
module tb_fsm_batch_ctrl;
  import fsm_ctrl_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        abort;
  logic        mode;
  logic [1:0]  state;
  logic [15:0] batch_cnt;

  int          total;
  int          bad;
  int          exp_batches;
  logic [9:0]  exp_q[$];

  fsm_batch_ctrl_if #(.DATA_W(8), .LOAD_BEATS(4)) bus ();

  fsm_batch_ctrl #(
    .DATA_W     (8),
    .LOAD_BEATS (4),
    .PROC_CYCLES(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .abort    (abort),
    .mode     (mode),
    .bus      (bus),
    .state    (state),
    .batch_cnt(batch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until the controller takes it.
  task automatic send_word(input logic [7:0] d, input logic m);
    int   n;
    logic was_ready;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    mode         = m;
    do begin
      was_ready = bus.in_ready;
      tick();
      n++;
    end while (!was_ready && n < 50);
    check_eq("accept", 32'(was_ready), 32'd1);
  endtask

  // Drive a 4-word batch (word 0 in bits 7:0) and queue its expected result.
  task automatic run_batch(input logic [31:0] w, input logic m_first,
                           input logic m_rest, input int gap);
    logic [9:0] e;
    logic [7:0] b;
    e = 10'(w[7:0]);
    for (int i = 1; i < 4; i++) begin
      b = w[8*i +: 8];
      e = m_first ? (e ^ 10'(b)) : (e + 10'(b));
    end
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && gap > 0) begin
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick();
          check_eq("gap_state", 32'(state), 32'(LOAD));
        end
      end
      send_word(w[8*i +: 8], (i == 0) ? m_first : m_rest);
    end
    bus.in_valid = 1'b0;
  endtask

  // Accept one result and compare it with the head of the scoreboard.
  task automatic receive_result(input string tag);
    int         n;
    logic [9:0] e;
    n = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_ovalid"}, 32'(bus.out_valid), 32'd1);
    if (bus.out_valid) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
      check_eq({tag, "_data"}, 32'(bus.out_data), 32'(e));
      $display("result %s data=%03h exp=%03h", tag, bus.out_data, e);
      tick();
      exp_batches++;
      check_eq({tag, "_bcnt"}, 32'(batch_cnt), 32'(exp_batches));
      check_eq({tag, "_idle"}, 32'(state), 32'(IDLE));
      check_eq({tag, "_vlow"}, 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;
  endtask

  // Sum batch with cycle-exact state trace and result latency.
  task automatic sum_with_states(input string tag);
    exp_q.push_back(10'h0A0);
    bus.in_valid = 1'b1;
    mode = MODE_SUM;
    check_eq({tag, "_st0"}, 32'(state), 32'(IDLE));
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'((i + 1) * 16);
      check_eq({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      tick();
      check_eq({tag, "_st"}, 32'(state), (i == 3) ? 32'(PROCESS) : 32'(LOAD));
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq({tag, "_stp"}, 32'(state), 32'(PROCESS));
      check_eq({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    end
    tick();
    check_eq({tag, "_std"}, 32'(state), 32'(DONE));
    check_eq({tag, "_lat"}, 32'(bus.out_valid), 32'd1);
    receive_result(tag);
  endtask

  initial begin
    int         n;
    logic [9:0] held;
    logic [15:0] cnt_before;
    total = 0;
    bad = 0;
    exp_batches = 0;
    abort = 1'b0;
    mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check_eq("rst_state", 32'(state), 32'(IDLE));
    check_eq("rst_ovalid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_ordy", 32'(bus.in_ready), 32'd0);
    check_eq("rst_odata", 32'(bus.out_data), 32'd0);
    check_eq("rst_bcnt", 32'(batch_cnt), 32'd0);
    #19 reset_n = 1'b1;
    tick();

    // Sum with state trace.
    sum_with_states("sum");

    // XOR, mode toggled on later beats.
    run_batch(32'h01F00FFF, MODE_XOR, MODE_SUM, 0);
    receive_result("xor");

    // Full-width sum with gaps between words.
    run_batch(32'hFFFFFFFF, MODE_SUM, MODE_XOR, 2);
    receive_result("wide");

    // Backpressure: result must hold while out_ready is low.
    run_batch(32'h11223344, MODE_SUM, MODE_SUM, 0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    held = bus.out_data;
    check_eq("bp_front", 32'(held), 32'(exp_q[0]));
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_data", 32'(bus.out_data), 32'(held));
      check_eq("bp_irdy", 32'(bus.in_ready), 32'd0);
    end
    receive_result("bp");

    // Abort after two beats; the word presented with abort is dropped.
    cnt_before = batch_cnt;
    send_word(8'h01, MODE_SUM);
    send_word(8'h02, MODE_SUM);
    bus.in_data = 8'h03;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("abort_state", 32'(state), 32'(IDLE));
    check_eq("abort_bcnt", 32'(batch_cnt), 32'(cnt_before));
    check_eq("abort_ovalid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_irdy", 32'(bus.in_ready), 32'd1);
    run_batch(32'h04030201, MODE_SUM, MODE_SUM, 0);
    receive_result("post_abort");

    // Asynchronous reset in the middle of PROCESS.
    run_batch(32'h55555555, MODE_SUM, MODE_SUM, 0);
    tick();
    check_eq("pre_rst_state", 32'(state), 32'(PROCESS));
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'(IDLE));
    check_eq("arst_ovalid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_irdy", 32'(bus.in_ready), 32'd0);
    check_eq("arst_odata", 32'(bus.out_data), 32'd0);
    check_eq("arst_bcnt", 32'(batch_cnt), 32'd0);
    exp_q.delete();
    exp_batches = 0;
    #2 reset_n = 1'b1;
    tick();
    sum_with_states("sum2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
